rs232_tx_scheduler: RTL and testbench
=====================================

RS232_TX_SCHEDULER -- requirements
Module: rs232_tx_scheduler

Interface
REQ-001 Parameter FIFO_SIZE, default 3, log2 of the FIFO depth; DEPTH = 2^FIFO_SIZE entries.
REQ-002 Parameter DATA_WIDTH, default 8, byte width of the write, FIFO and transmitter data.
REQ-003 Port clk  input  1  system clock; all logic is rising-edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port clear  input  1  synchronous soft flush, active-high.
REQ-006 Port wr_valid  input  1  host offers a byte.
REQ-007 Port wr_data  input  DATA_WIDTH  host byte.
REQ-008 Port wr_ready  output  1  scheduler accepts the byte this cycle.
REQ-009 Port fifo_push_clock  output  1  push strobe to the fifo.
REQ-010 Port fifo_pop_clock  output  1  pop strobe to the fifo.
REQ-011 Port fifo_in_data  output  DATA_WIDTH  byte presented to the fifo.
REQ-012 Port fifo_out_data  input  DATA_WIDTH  byte returned by the fifo.
REQ-013 Port fifo_clear  output  1  clear to the fifo.
REQ-014 Port tx_busy  input  1  serial transmitter is sending.
REQ-015 Port tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-016 Port tx_data  output  DATA_WIDTH  byte for the transmitter.
REQ-017 Port count  output  FIFO_SIZE+1  FIFO occupancy.
REQ-018 Ports full and empty  output  1 each  count==DEPTH and count==0.

Function
REQ-019 The push FSM SHALL use states P_IDLE, P_SETUP, P_STROBE and P_HOLD; all outputs are registered.
REQ-020 In P_IDLE, wr_ready SHALL be 1 iff count<DEPTH and clear==0; in every other push state it SHALL be 0.
REQ-021 A write SHALL be accepted when wr_valid && wr_ready: fifo_in_data <= wr_data, then P_SETUP.
REQ-022 The push sequence SHALL be P_SETUP (strobe 0), P_STROBE (fifo_push_clock=1, count +1), P_HOLD (strobe 0), then P_IDLE; fifo_in_data is stable throughout, giving at most one write per 4 cycles.
REQ-023 The pop FSM SHALL use states T_IDLE, T_STROBE, T_CAPTURE, T_START and T_WAIT.
REQ-024 The pop FSM SHALL leave T_IDLE for T_STROBE only when count>0 && tx_busy==0 && clear==0; it SHALL never pop when empty.
REQ-025 In T_STROBE, fifo_pop_clock SHALL be 1 and count SHALL decrement by 1.
REQ-026 In T_CAPTURE, the strobe SHALL be 0 and tx_data <= fifo_out_data.
REQ-027 In T_START, tx_start SHALL be 1 for exactly one cycle.
REQ-028 T_WAIT SHALL hold until tx_busy==1, then return to T_IDLE.
REQ-029 When push increment and pop decrement fall in the same cycle, count SHALL be unchanged.
REQ-030 count SHALL never exceed DEPTH nor wrap below 0; full SHALL block further acceptance.
REQ-031 With clear==1, both FSMs SHALL go idle next cycle, both strobes SHALL go 0, count SHALL go 0, a pending tx_start SHALL be suppressed, and fifo_clear SHALL be the registered copy of clear.

Reset
REQ-032 While rst_n==0, all outputs SHALL be 0 (wr_ready, strobes, tx_start, fifo_clear, fifo_in_data, tx_data, count), empty SHALL be 1, full SHALL be 0, and both FSMs SHALL be idle.
REQ-033 On rst_n deassertion mid-sequence, no partial strobe SHALL be emitted; wr_ready SHALL rise on the first clk edge after release.

Structure
REQ-034 Package rs232_pkg SHALL hold the DATA_WIDTH and FIFO_SIZE defaults and both FSM state encodings.
REQ-035 Occupancy tracking SHALL be the sub-module fifo_occupancy (inc, dec, clear → count, full, empty); the fifo itself is instantiated outside this block.

Verification
REQ-036 Reset then idle: count=0, empty=1, wr_ready=1, no strobes.
REQ-037 Write 8'hAC with tx_busy=0: one fifo_push_clock pulse 2 cycles after acceptance, then fifo_pop_clock, then tx_data=8'hAC with one tx_start pulse; count returns to 0.
REQ-038 Hold tx_busy=1 and write 8 bytes: count=8, full=1, wr_ready=0; a ninth wr_valid is not accepted and produces no push strobe.
REQ-039 Coincident push strobe and pop strobe at count=3: count stays 3.
REQ-040 Assert clear during T_CAPTURE with count=2: next cycle count=0, fifo_clear=1, no tx_start.
REQ-041 Write 8'hAC then 8'h61 with tx_busy toggling: tx_data order is AC, 61; exactly two tx_start pulses.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared defaults and FSM state encodings for the RS232 transmit scheduler.
package rs232_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned FIFO_SIZE_DEF  = 3;

    // Write side: one accepted byte walks through setup / strobe / hold.
    typedef enum logic [1:0] {
        P_IDLE,
        P_SETUP,
        P_STROBE,
        P_HOLD
    } push_state_t;

    // Read side: pop the fifo, capture its output, kick the transmitter.
    typedef enum logic [2:0] {
        T_IDLE,
        T_STROBE,
        T_CAPTURE,
        T_START,
        T_WAIT
    } pop_state_t;

endpackage

// File: rtl/fifo_occupancy.sv
// Occupancy counter for the external fifo: tracks push/pop strobes.
module fifo_occupancy
    import rs232_pkg::*;
#(
    parameter int unsigned FIFO_SIZE = FIFO_SIZE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               dec,
    input  logic               clear,
    output logic [FIFO_SIZE:0] count,
    output logic               full,
    output logic               empty
);

    localparam logic [FIFO_SIZE:0] DEPTH_CNT = {1'b1, {FIFO_SIZE{1'b0}}};
    localparam logic [FIFO_SIZE:0] ONE_CNT   = {{FIFO_SIZE{1'b0}}, 1'b1};

    // Saturating up/down count; simultaneous inc and dec cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !dec && (count != DEPTH_CNT)) begin
            count <= count + ONE_CNT;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - ONE_CNT;
        end
    end

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/rs232_tx_scheduler.sv
// Moves host bytes into an external fifo and feeds them to a serial
// transmitter one at a time, keeping an occupancy count of the fifo.
module rs232_tx_scheduler
    import rs232_pkg::*;
#(
    parameter int unsigned FIFO_SIZE  = FIFO_SIZE_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  fifo_push_clock,
    output logic                  fifo_pop_clock,
    output logic [DATA_WIDTH-1:0] fifo_in_data,
    input  logic [DATA_WIDTH-1:0] fifo_out_data,
    output logic                  fifo_clear,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [FIFO_SIZE:0]    count,
    output logic                  full,
    output logic                  empty
);

    push_state_t           p_state, p_next;
    pop_state_t            t_state, t_next;
    logic                  wr_ready_d, push_d, pop_d, tx_start_d;
    logic [DATA_WIDTH-1:0] fifo_in_data_d, tx_data_d;

    // Occupancy moves on the same edge the corresponding strobe rises, so
    // count already reflects a strobe while that strobe is high.
    fifo_occupancy #(
        .FIFO_SIZE (FIFO_SIZE)
    ) u_occupancy (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push_d),
        .dec   (pop_d),
        .clear (clear),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Push sequencing; wr_ready is precomputed for the state being entered.
    always_comb begin
        p_next         = p_state;
        fifo_in_data_d = fifo_in_data;
        if (clear) begin
            p_next = P_IDLE;
        end else begin
            case (p_state)
                P_IDLE: begin
                    if (wr_valid && wr_ready) begin
                        p_next         = P_SETUP;
                        fifo_in_data_d = wr_data;
                    end
                end
                P_SETUP:  p_next = P_STROBE;
                P_STROBE: p_next = P_HOLD;
                P_HOLD:   p_next = P_IDLE;
                default:  p_next = P_IDLE;
            endcase
        end
        push_d     = (p_next == P_STROBE);
        wr_ready_d = (p_next == P_IDLE) && !clear && !full;
    end

    // Push state register and registered push outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state         <= P_IDLE;
            wr_ready        <= 1'b0;
            fifo_push_clock <= 1'b0;
            fifo_in_data    <= '0;
        end else begin
            p_state         <= p_next;
            wr_ready        <= wr_ready_d;
            fifo_push_clock <= push_d;
            fifo_in_data    <= fifo_in_data_d;
        end
    end

    // Pop sequencing; only leaves idle when data exists and the line is free.
    always_comb begin
        t_next    = t_state;
        tx_data_d = tx_data;
        if (clear) begin
            t_next = T_IDLE;
        end else begin
            case (t_state)
                T_IDLE: begin
                    if (!empty && !tx_busy) begin
                        t_next = T_STROBE;
                    end
                end
                T_STROBE: t_next = T_CAPTURE;
                T_CAPTURE: begin
                    t_next    = T_START;
                    tx_data_d = fifo_out_data;
                end
                T_START: t_next = T_WAIT;
                T_WAIT: begin
                    if (tx_busy) begin
                        t_next = T_IDLE;
                    end
                end
                default: t_next = T_IDLE;
            endcase
        end
        pop_d      = (t_next == T_STROBE);
        tx_start_d = (t_next == T_START);
    end

    // Pop state register, registered pop outputs and the fifo clear copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_state        <= T_IDLE;
            fifo_pop_clock <= 1'b0;
            tx_start       <= 1'b0;
            tx_data        <= '0;
            fifo_clear     <= 1'b0;
        end else begin
            t_state        <= t_next;
            fifo_pop_clock <= pop_d;
            tx_start       <= tx_start_d;
            tx_data        <= tx_data_d;
            fifo_clear     <= clear;
        end
    end

endmodule

// File: tb/tb_rs232_tx_scheduler.sv
// Self-checking bench: models the external fifo and a transmitter, and
// checks the scheduler against an in-order byte/occupancy reference.
module tb_rs232_tx_scheduler;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n, clear, wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready, fifo_push_clock, fifo_pop_clock, fifo_clear;
    logic [7:0] fifo_in_data;
    logic [7:0] fifo_out_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [3:0] count;
    logic       full, empty;

    rs232_tx_scheduler #(
        .FIFO_SIZE  (3),
        .DATA_WIDTH (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .wr_valid        (wr_valid),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .fifo_push_clock (fifo_push_clock),
        .fifo_pop_clock  (fifo_pop_clock),
        .fifo_in_data    (fifo_in_data),
        .fifo_out_data   (fifo_out_data),
        .fifo_clear      (fifo_clear),
        .tx_busy         (tx_busy),
        .tx_start        (tx_start),
        .tx_data         (tx_data),
        .count           (count),
        .full            (full),
        .empty           (empty)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference state: accepted bytes awaiting their push strobe, bytes in
    // the fifo in order, bytes popped and owed to the transmitter.
    typedef struct {
        logic [7:0]  d;
        int unsigned c;
    } acc_t;

    acc_t        pend_q[$];
    logic [7:0]  model_q[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  env_q[$];
    logic [7:0]  tx_log[$];
    int          mcount = 0;
    int unsigned cyc = 0;
    int unsigned start_cnt = 0;
    int          tx_mode = 2;      // 0: busy low, 1: busy high, 2: reacts to tx_start
    int          tx_wait_cnt = 0;
    int          tx_hold_cnt = 0;
    logic        auto_busy = 1'b0;
    logic        prev_start = 1'b0;

    // Fifo model, transmitter model and scoreboard, all sampled mid-cycle.
    always @(negedge clk) begin
        acc_t a;
        cyc++;
        if (!rst_n) begin
            pend_q.delete(); model_q.delete(); exp_tx.delete(); env_q.delete();
            mcount = 0; prev_start = 1'b0; tx_wait_cnt = 0; tx_hold_cnt = 0;
        end else begin
            if (fifo_clear) begin
                pend_q.delete(); model_q.delete(); exp_tx.delete(); env_q.delete();
                mcount = 0;
            end
            if (fifo_pop_clock) begin
                check("pop_when_nonempty", 32'(mcount > 0), 1);
                if (env_q.size() > 0) fifo_out_data = env_q.pop_front();
                if (model_q.size() > 0) exp_tx.push_back(model_q.pop_front());
                mcount--;
            end
            if (fifo_push_clock) begin
                check("push_expected", 32'(pend_q.size() > 0), 1);
                if (pend_q.size() > 0) begin
                    a = pend_q.pop_front();
                    check("push_latency", cyc - a.c, 2);
                    check("push_data", fifo_in_data, a.d);
                    model_q.push_back(a.d);
                end
                env_q.push_back(fifo_in_data);
                mcount++;
            end
            if (tx_start) begin
                check("start_single_cycle", prev_start, 0);
                check("start_expected", 32'(exp_tx.size() > 0), 1);
                if (exp_tx.size() > 0) check("tx_data_order", tx_data, exp_tx.pop_front());
                tx_log.push_back(tx_data);
                start_cnt++;
                tx_wait_cnt = $urandom_range(1, 3);
                tx_hold_cnt = $urandom_range(2, 5);
            end
            prev_start = tx_start;
            if (wr_valid && wr_ready && !clear) pend_q.push_back('{d: wr_data, c: cyc});
            check("count", count, mcount);
            check("full", full, 32'(mcount == DEPTH));
            check("empty", empty, 32'(mcount == 0));
            check("ready_blocked_when_full", 32'(wr_ready && (mcount == DEPTH)), 0);
        end
        if (tx_wait_cnt > 0) begin
            tx_wait_cnt--; auto_busy = 1'b0;
        end else if (tx_hold_cnt > 0) begin
            tx_hold_cnt--; auto_busy = 1'b1;
        end else begin
            auto_busy = 1'b0;
        end
        tx_busy = (tx_mode == 2) ? auto_busy : (tx_mode == 1);
    end

    // Offer one byte and hold it until accepted; returns just after the accept edge.
    task automatic do_write(input logic [7:0] d);
        int unsigned guard = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        while (!wr_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("write_accepted", wr_ready, 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    // Let everything in flight reach the transmitter, then confirm idle.
    task automatic drain(input string tag);
        int unsigned n = 0;
        wr_valid = 1'b0;
        while (n < 400 && !(pend_q.size() == 0 && model_q.size() == 0 && exp_tx.size() == 0
                            && tx_wait_cnt == 0 && tx_hold_cnt == 0 && !tx_busy)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_outstanding"}, pend_q.size() + model_q.size() + exp_tx.size(), 0);
        check({tag, "_count"}, count, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned snap_cnt, snap_log;
        rst_n = 1'b0; clear = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        // Outputs while held in reset
        check("rst_wr_ready", wr_ready, 0);
        check("rst_push", fifo_push_clock, 0);
        check("rst_pop", fifo_pop_clock, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_fifo_clear", fifo_clear, 0);
        check("rst_fifo_in_data", fifo_in_data, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_first_edge", wr_ready, 0);
        @(posedge clk); #1;
        check("ready_after_first_edge", wr_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        check("idle_count", count, 0);
        check("idle_empty", empty, 1);
        check("idle_no_push", fifo_push_clock, 0);
        check("idle_no_pop", fifo_pop_clock, 0);

        // Single byte end to end
        snap_cnt = start_cnt; snap_log = tx_log.size();
        do_write(8'hAC);
        @(negedge clk);
        check("ac_setup_no_push", fifo_push_clock, 0);
        @(negedge clk);
        check("ac_push", fifo_push_clock, 1);
        check("ac_push_data", fifo_in_data, 8'hAC);
        check("ac_count_one", count, 1);
        @(negedge clk);
        check("ac_pop", fifo_pop_clock, 1);
        check("ac_count_zero", count, 0);
        drain("ac");
        check("ac_starts", start_cnt - snap_cnt, 1);
        check("ac_tx_data", tx_log[snap_log], 8'hAC);

        // Fill to full with the transmitter busy, then try a ninth byte
        tx_mode = 1;
        for (int i = 0; i < DEPTH; i++) do_write(8'(8'h10 + i));
        repeat (4) @(posedge clk);
        #1;
        check("full_count", count, DEPTH);
        check("full_flag", full, 1);
        check("full_ready", wr_ready, 0);
        wr_valid = 1'b1; wr_data = 8'hEE;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("ninth_not_ready", wr_ready, 0);
            check("ninth_no_push", fifo_push_clock, 0);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        tx_mode = 2;
        drain("full");
        repeat (10) @(posedge clk);
        #1;

        // Push and pop strobes on the same edge at count 3
        tx_mode = 1;
        for (int i = 0; i < 3; i++) do_write(8'(8'h30 + i));
        repeat (4) @(posedge clk);
        #1;
        check("coinc_pre_count", count, 3);
        do_write(8'h33);
        tx_mode = 2;
        @(negedge clk);
        @(negedge clk);
        check("coinc_push", fifo_push_clock, 1);
        check("coinc_pop", fifo_pop_clock, 1);
        check("coinc_count", count, 3);
        drain("coinc");
        repeat (10) @(posedge clk);
        #1;

        // Clear while a popped byte is being captured
        tx_mode = 1;
        for (int i = 0; i < 3; i++) do_write(8'(8'h50 + i));
        repeat (4) @(posedge clk);
        #1;
        snap_cnt = start_cnt;
        tx_mode = 2;
        begin
            int unsigned g = 0;
            @(negedge clk);
            while (!fifo_pop_clock && g < 20) begin
                @(negedge clk);
                g++;
            end
        end
        check("clr_pop_seen", fifo_pop_clock, 1);
        check("clr_pre_count", count, 2);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr_count", count, 0);
        check("clr_fifo_clear", fifo_clear, 1);
        check("clr_no_start", tx_start, 0);
        repeat (6) @(negedge clk);
        check("clr_start_suppressed", start_cnt - snap_cnt, 0);
        check("clr_idle_count", count, 0);
        @(posedge clk); #1;

        // Two bytes in order with the transmitter toggling busy
        snap_cnt = start_cnt; snap_log = tx_log.size();
        do_write(8'hAC);
        do_write(8'h61);
        drain("pair");
        check("pair_starts", start_cnt - snap_cnt, 2);
        check("pair_first", tx_log[snap_log], 8'hAC);
        check("pair_second", tx_log[snap_log + 1], 8'h61);

        // Reset in the middle of a push sequence
        do_write(8'h5A);
        rst_n = 1'b0;
        #1;
        check("midrst_push", fifo_push_clock, 0);
        check("midrst_ready", wr_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_push", fifo_push_clock, 0);
            check("midrst_ready_rise", wr_ready, 32'(i > 0));
        end
        @(posedge clk); #1;

        // Randomized traffic with occasional flushes
        tx_mode = 2;
        for (int i = 0; i < 400; i++) begin
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_data  = 8'($urandom);
            clear    = !wr_valid && ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        clear = 1'b0;
        drain("random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
